// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding used by both TX and RX,
// plus the stop-period tick presets for OS=16.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int SB_1   = 16;
   localparam int SB_1P5 = 24;
   localparam int SB_2   = 32;

endpackage

// File: rtl/uart_tx_if.sv
// Baud tick, TX FIFO read side and serial outputs of the UART transmitter.
interface uart_tx_if #(
   parameter int DBIT = 8
) ();

   logic            s_tick;
   logic            fifo_empty;
   logic [DBIT-1:0] fifo_dout;
   logic            fifo_rd;
   logic            tx;
   logic            tx_busy;
   logic            tx_done_tick;

   modport master (
      input  s_tick,
      input  fifo_empty,
      input  fifo_dout,
      output fifo_rd,
      output tx,
      output tx_busy,
      output tx_done_tick
   );

   modport slave (
      output s_tick,
      output fifo_empty,
      output fifo_dout,
      input  fifo_rd,
      input  tx,
      input  tx_busy,
      input  tx_done_tick
   );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: pops one FIFO word when available and sends it LSB-first
// as start bit, DBIT data bits and a SB_TICK-tick stop period.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = 8,
   parameter int OS      = 16,
   parameter int SB_TICK = SB_1
) (
   input  logic     clk,
   input  logic     Reset,
   uart_tx_if.master bus
);

   localparam int S_MAX = (OS > SB_TICK) ? OS : SB_TICK;
   localparam int SCW   = (S_MAX > 1) ? $clog2(S_MAX) : 1;
   localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;

   tx_state_t       state_q, state_d;
   logic [SCW-1:0]  s_cnt_q, s_cnt_d;
   logic [NW-1:0]   n_cnt_q, n_cnt_d;
   logic [DBIT-1:0] shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            fifo_rd_s;
   logic            done_s;

   // State, counters, shift register and the registered tx line.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         s_cnt_q <= '0;
         n_cnt_q <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         s_cnt_q <= s_cnt_d;
         n_cnt_q <= n_cnt_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

   // Next-state logic, pop strobe and done pulse.
   always_comb begin
      state_d   = state_q;
      s_cnt_d   = s_cnt_q;
      n_cnt_d   = n_cnt_q;
      shreg_d   = shreg_q;
      fifo_rd_s = 1'b0;
      done_s    = 1'b0;
      tx_d      = 1'b1;

      case (state_q)
         IDLE: begin
            // Pop is gated by Reset so no strobe leaks out while held in reset.
            if (!bus.fifo_empty && !Reset) begin
               fifo_rd_s = 1'b1;
               shreg_d   = bus.fifo_dout;
               s_cnt_d   = '0;
               state_d   = START;
            end else begin
               state_d   = IDLE;
            end
         end
         START: begin
            if (bus.s_tick) begin
               if (s_cnt_q == SCW'(OS - 1)) begin
                  s_cnt_d = '0;
                  n_cnt_d = '0;
                  state_d = DATA;
               end else begin
                  s_cnt_d = s_cnt_q + SCW'(1);
               end
            end else begin
               s_cnt_d = s_cnt_q;
            end
         end
         DATA: begin
            if (bus.s_tick) begin
               if (s_cnt_q == SCW'(OS - 1)) begin
                  s_cnt_d = '0;
                  shreg_d = shreg_q >> 1;
                  if (n_cnt_q == NW'(DBIT - 1)) begin
                     state_d = STOP;
                  end else begin
                     n_cnt_d = n_cnt_q + NW'(1);
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SCW'(1);
               end
            end else begin
               s_cnt_d = s_cnt_q;
            end
         end
         STOP: begin
            if (bus.s_tick) begin
               if (s_cnt_q == SCW'(SB_TICK - 1)) begin
                  done_s  = 1'b1;
                  state_d = IDLE;
               end else begin
                  s_cnt_d = s_cnt_q + SCW'(1);
               end
            end else begin
               s_cnt_d = s_cnt_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // tx follows the state being entered, so the start bit begins one clk after the pop.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shreg_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign bus.fifo_rd      = fifo_rd_s;
   assign bus.tx           = tx_q;
   assign bus.tx_busy      = (state_q != IDLE) | fifo_rd_s;
   assign bus.tx_done_tick = done_s;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: an 8N1 instance and a 7-bit,
// two-stop-bit instance share clock, reset and a tick every 2 clk.
module tb_uart_tx;

   logic clk   = 1'b0;
   logic Reset = 1'b1;
   logic ph    = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   uart_tx_if #(.DBIT(8)) bus8 ();
   uart_tx_if #(.DBIT(7)) bus7 ();

   uart_tx #(.DBIT(8), .OS(16), .SB_TICK(16)) dut8 (.clk(clk), .Reset(Reset), .bus(bus8));
   uart_tx #(.DBIT(7), .OS(16), .SB_TICK(32)) dut7 (.clk(clk), .Reset(Reset), .bus(bus7));

   always #5 clk = ~clk;

   // Oversampling tick on every other clock.
   initial begin
      bus8.s_tick = 1'b0;
      bus7.s_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ph          = ~ph;
         bus8.s_tick = ph;
         bus7.s_tick = ph;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected tx level after t ticks counted since the pop cycle.
   function automatic logic exp_tx(input logic [8:0] word, input int dbit, input int t);
      int idx;
      idx = t / 16;
      if (idx == 0)         return 1'b0;
      else if (idx <= dbit) return word[idx-1];
      else                  return 1'b1;
   endfunction

   task automatic set_fifo(input int which, input logic empty, input logic [8:0] word);
      if (which == 1) begin
         bus7.fifo_empty = empty;
         bus7.fifo_dout  = word[6:0];
      end else begin
         bus8.fifo_empty = empty;
         bus8.fifo_dout  = word[7:0];
      end
   endtask

   // Waits for a pop, then checks every clock of the frame against the tick model.
   task automatic frame_check(input string tag, input int which, input logic [8:0] word,
                              input int dbit, input int sbt, input int max_wait,
                              input logic nxt_empty, input logic [8:0] nxt_word);
      int  total;
      int  t;
      bit  seen;
      logic o_tx, o_rd, o_busy, o_done, o_tick;
      total = (1 + dbit) * 16 + sbt;
      seen  = 1'b0;
      for (int i = 0; i < max_wait && !seen; i++) begin
         @(negedge clk);
         o_rd   = which ? bus7.fifo_rd : bus8.fifo_rd;
         o_busy = which ? bus7.tx_busy : bus8.tx_busy;
         o_tx   = which ? bus7.tx      : bus8.tx;
         if (o_rd) begin
            seen = 1'b1;
            check_eq({tag, "_pop_busy"}, 32'(o_busy), 32'd1);
            check_eq({tag, "_pop_tx"}, 32'(o_tx), 32'd1);
         end
      end
      if (!seen) begin
         check_eq({tag, "_pop_timeout"}, 32'd0, 32'd1);
         return;
      end
      @(posedge clk);
      #1;
      set_fifo(which, nxt_empty, nxt_word);
      t = 0;
      for (int c = 0; c < 2 * total + 16; c++) begin
         @(negedge clk);
         o_tx   = which ? bus7.tx           : bus8.tx;
         o_rd   = which ? bus7.fifo_rd      : bus8.fifo_rd;
         o_busy = which ? bus7.tx_busy      : bus8.tx_busy;
         o_done = which ? bus7.tx_done_tick : bus8.tx_done_tick;
         o_tick = which ? bus7.s_tick       : bus8.s_tick;
         check_eq($sformatf("%s_tx_t%0d", tag, t), 32'(o_tx), 32'(exp_tx(word, dbit, t)));
         check_eq({tag, "_rd"}, 32'(o_rd), 32'd0);
         check_eq({tag, "_busy"}, 32'(o_busy), 32'd1);
         check_eq($sformatf("%s_done_t%0d", tag, t), 32'(o_done),
                  32'(o_tick && (t == total - 1)));
         if (o_tick && (t == total - 1)) return;
         if (o_tick) t++;
      end
      check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      int t;
      bit seen;
      set_fifo(0, 1'b0, 9'h0A5);
      set_fifo(1, 1'b1, 9'h000);

      // Reset held with data available: outputs stay idle, no pop.
      repeat (3) begin
         @(negedge clk);
         check_eq("rst_tx", 32'(bus8.tx), 32'd1);
         check_eq("rst_rd", 32'(bus8.fifo_rd), 32'd0);
         check_eq("rst_busy", 32'(bus8.tx_busy), 32'd0);
         check_eq("rst_done", 32'(bus8.tx_done_tick), 32'd0);
      end
      @(posedge clk);
      #1;
      Reset = 1'b0;

      // Single 0xA5 frame, FIFO drains after the pop.
      frame_check("a5", 0, 9'h0A5, 8, 16, 1, 1'b1, 9'h0A5);

      // Empty FIFO: line idle, no pops.
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         check_eq("idle_tx", 32'(bus8.tx), 32'd1);
         check_eq("idle_rd", 32'(bus8.fifo_rd), 32'd0);
         check_eq("idle_busy", 32'(bus8.tx_busy), 32'd0);
         check_eq("idle_done", 32'(bus8.tx_done_tick), 32'd0);
      end

      // Back-to-back 0x00 then 0xFF: second pop in the very next clock.
      @(posedge clk);
      #1;
      set_fifo(0, 1'b0, 9'h000);
      frame_check("b00", 0, 9'h000, 8, 16, 2, 1'b0, 9'h0FF);
      frame_check("bff", 0, 9'h0FF, 8, 16, 1, 1'b1, 9'h0FF);

      // 0x3C aborted by reset in data bit 3; 0x81 waits behind it.
      @(posedge clk);
      #1;
      set_fifo(0, 1'b0, 9'h03C);
      seen = 1'b0;
      for (int i = 0; i < 4 && !seen; i++) begin
         @(negedge clk);
         seen = bus8.fifo_rd;
      end
      check_eq("ab_pop", 32'(seen), 32'd1);
      @(posedge clk);
      #1;
      set_fifo(0, 1'b0, 9'h081);
      t = 0;
      for (int c = 0; c < 400 && t < 72; c++) begin
         @(negedge clk);
         check_eq($sformatf("ab_tx_t%0d", t), 32'(bus8.tx), 32'(exp_tx(9'h03C, 8, t)));
         check_eq("ab_done", 32'(bus8.tx_done_tick), 32'd0);
         if (bus8.s_tick) t++;
      end
      check_eq("ab_reached_bit3", 32'(t), 32'd72);
      #1;
      Reset = 1'b1;
      #1;
      check_eq("ab_async_tx", 32'(bus8.tx), 32'd1);
      check_eq("ab_async_busy", 32'(bus8.tx_busy), 32'd0);
      repeat (2) begin
         @(negedge clk);
         check_eq("ab_rst_tx", 32'(bus8.tx), 32'd1);
         check_eq("ab_rst_done", 32'(bus8.tx_done_tick), 32'd0);
         check_eq("ab_rst_rd", 32'(bus8.fifo_rd), 32'd0);
      end
      @(posedge clk);
      #1;
      Reset = 1'b0;
      frame_check("r81", 0, 9'h081, 8, 16, 1, 1'b1, 9'h081);

      // 7 data bits, 32-tick stop period.
      @(posedge clk);
      #1;
      set_fifo(1, 1'b0, 9'h055);
      frame_check("s55", 1, 9'h055, 7, 32, 2, 1'b1, 9'h055);
      @(negedge clk);
      check_eq("s55_after_tx", 32'(bus7.tx), 32'd1);
      check_eq("s55_after_busy", 32'(bus7.tx_busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
